// File: rtl/golden_nonce_reporter.sv
// golden_nonce_reporter: queues golden nonces and streams each as a sync-prefixed 5-byte frame
module golden_nonce_reporter #(
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              nonce_in,
    input  logic                     nonce_valid,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow,
    input  logic                     clear_overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, SYNC, B3, B2, B1, B0} state_t;

    state_t                     state, state_n;
    logic [31:0]                mem [DEPTH];
    logic [31:0]                holding;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [7:0]                 tx_data_n;
    logic                       tx_valid_n, pop, push, drop, full;

    // count only reaches its top bit when every slot is occupied
    assign full = fifo_count[FIFO_DEPTH_LOG2];
    assign push = nonce_valid && (!full || pop);
    assign drop = nonce_valid && full && !pop;

    // frame sequencer: pop in IDLE, then step through sync and nonce bytes on each handshake
    always_comb begin
        state_n    = state;
        tx_valid_n = tx_valid;
        tx_data_n  = tx_data;
        pop        = 1'b0;
        if (state == IDLE) begin
            if (fifo_count != '0) begin
                pop        = 1'b1;
                state_n    = SYNC;
                tx_valid_n = 1'b1;
                tx_data_n  = SYNC_BYTE;
            end
        end else if (tx_valid && tx_ready) begin
            case (state)
                SYNC:    begin state_n = B3; tx_data_n = holding[31:24]; end
                B3:      begin state_n = B2; tx_data_n = holding[23:16]; end
                B2:      begin state_n = B1; tx_data_n = holding[15:8]; end
                B1:      begin state_n = B0; tx_data_n = holding[7:0]; end
                default: begin state_n = IDLE; tx_valid_n = 1'b0; end
            endcase
        end
    end

    // FSM, registered stream outputs, FIFO bookkeeping and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            holding    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            tx_valid   <= tx_valid_n;
            tx_data    <= tx_data_n;
            holding    <= pop ? mem[rd_ptr] : holding;
            wr_ptr     <= push ? wr_ptr + PTR_ONE : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + PTR_ONE : rd_ptr;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            overflow   <= drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow);
        end
    end

    // FIFO storage needs no reset; pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= nonce_in;
    end
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// tb_golden_nonce_reporter: directed and randomized checks of framing, queueing, overflow and reset
module tb_golden_nonce_reporter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] nonce_in = '0;
    logic        nonce_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        clear_overflow = 1'b0;

    int          tests = 0;
    int          fails = 0;
    bit          rand_ready = 1'b0;
    bit          stall = 1'b0;
    logic [7:0]  held = '0;
    logic [7:0]  rx[$];
    logic [7:0]  exp_q[$];

    golden_nonce_reporter #(.FIFO_DEPTH_LOG2(2), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .nonce_in(nonce_in), .nonce_valid(nonce_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // collect accepted bytes and require a stalled byte to stay put
    always @(posedge clk) begin
        if (!reset_n) stall = 1'b0;
        else begin
            if (stall) begin
                check("hold_valid", {31'b0, tx_valid}, 1);
                check("hold_data", {24'b0, tx_data}, {24'b0, held});
            end
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            stall = tx_valid && !tx_ready;
            held = tx_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) tx_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic expect_frame(input logic [31:0] n);
        exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) exp_q.push_back(n[i*8 +: 8]);
    endtask

    task automatic strobe(input logic [31:0] n);
        nonce_in = n;
        nonce_valid = 1'b1;
        tick();
        nonce_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int c = 0;
        while (rx.size() < n && c < budget) begin
            tick();
            c++;
        end
        repeat (8) tick();
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            check($sformatf("%s[%0d]", tag, i), {24'b0, rx[i]}, {24'b0, exp_q[i]});
        rx.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  f1 [5];
        logic [31:0] r;
        int          pat [4];
        int          n;
        f1 = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pat = '{1, 0, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_tx_valid", {31'b0, tx_valid}, 0);
        check("rst_count", {29'b0, fifo_count}, 0);
        check("rst_overflow", {31'b0, overflow}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frame, continuous ready, exact cycle timing
        tx_ready = 1'b1;
        nonce_in = 32'hDEADBEEF;
        nonce_valid = 1'b1;
        @(negedge clk);
        nonce_valid = 1'b0;
        check("t1_count_after_write", {29'b0, fifo_count}, 1);
        check("t1_valid_before_sync", {31'b0, tx_valid}, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid%0d", k), {31'b0, tx_valid}, 1);
            check($sformatf("t1_data%0d", k), {24'b0, tx_data}, {24'b0, f1[k]});
        end
        @(negedge clk);
        check("t1_idle_gap", {31'b0, tx_valid}, 0);
        check("t1_count_end", {29'b0, fifo_count}, 0);
        repeat (3) @(negedge clk);
        expect_frame(32'hDEADBEEF);
        compare_rx("t1_stream");

        // toggling backpressure
        nonce_in = 32'hDEADBEEF;
        nonce_valid = 1'b1;
        tx_ready = pat[0] != 0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            nonce_valid = 1'b0;
            tx_ready = pat[c % 4] != 0;
        end
        expect_frame(32'hDEADBEEF);
        compare_rx("t2_stream");

        // overflow on the sixth nonce while stalled
        tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            nonce_in = i;
            nonce_valid = 1'b1;
            @(negedge clk);
        end
        nonce_valid = 1'b0;
        check("t3_overflow", {31'b0, overflow}, 1);
        check("t3_count", {29'b0, fifo_count}, 4);
        for (int i = 1; i <= 5; i++) expect_frame(i);

        // set beats clear, then clear alone
        nonce_in = 7;
        nonce_valid = 1'b1;
        clear_overflow = 1'b1;
        @(negedge clk);
        nonce_valid = 1'b0;
        check("t4_ovf_set_wins", {31'b0, overflow}, 1);
        check("t4_count", {29'b0, fifo_count}, 4);
        @(negedge clk);
        clear_overflow = 1'b0;
        check("t4_ovf_cleared", {31'b0, overflow}, 0);
        tx_ready = 1'b1;
        wait_bytes(25, 200);
        compare_rx("t3_stream");

        // push into a full FIFO in the same cycle the idle FSM pops
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            expect_frame(r);
            nonce_in = r;
            nonce_valid = 1'b1;
            @(negedge clk);
        end
        nonce_valid = 1'b0;
        check("t5_full", {29'b0, fifo_count}, 4);
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_idle", {31'b0, tx_valid}, 0);
        nonce_in = 32'h12345678;
        nonce_valid = 1'b1;
        @(negedge clk);
        nonce_valid = 1'b0;
        check("t5_count_same", {29'b0, fifo_count}, 4);
        check("t5_no_overflow", {31'b0, overflow}, 0);
        expect_frame(32'h12345678);
        wait_bytes(30, 200);
        compare_rx("t5_stream");

        // randomized bursts that never exceed capacity, random ready
        rand_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 3)) tick();
                r = $urandom;
                expect_frame(r);
                strobe(r);
            end
            wait_bytes(exp_q.size(), 400);
        end
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        check("rand_no_overflow", {31'b0, overflow}, 0);
        compare_rx("rand_stream");

        // asynchronous reset in the middle of a frame
        nonce_in = 32'hDEADBEEF;
        nonce_valid = 1'b1;
        @(negedge clk);
        nonce_in = 32'hCAFEF00D;
        @(negedge clk);
        nonce_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_bytes_before", rx.size(), 2);
        check("t6_count_before", {29'b0, fifo_count}, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_valid_async", {31'b0, tx_valid}, 0);
        check("t6_count_async", {29'b0, fifo_count}, 0);
        rx.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_leftover", rx.size(), 0);
        expect_frame(32'h00000001);
        strobe(32'h00000001);
        wait_bytes(5, 50);
        compare_rx("t6_stream");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
